// File: rtl/cnn_grid_unloader.sv
// Captures the 16 CNN cell outputs after a fixed sweep count and streams them out in raster order.
// CNN_UNLOAD_BINARY_EN selects sign-only (+1/-1) pixels instead of shift-and-saturate.
module cnn_grid_unloader #(
    parameter int WIDTH  = 9,
    parameter int SHIFT  = 8,
    parameter int SWEEPS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      sweep_tick,
    input  logic signed [2*WIDTH-1:0] Y1_in,
    input  logic signed [2*WIDTH-1:0] Y2_in,
    input  logic signed [2*WIDTH-1:0] Y3_in,
    input  logic signed [2*WIDTH-1:0] Y4_in,
    input  logic signed [2*WIDTH-1:0] Y5_in,
    input  logic signed [2*WIDTH-1:0] Y6_in,
    input  logic signed [2*WIDTH-1:0] Y7_in,
    input  logic signed [2*WIDTH-1:0] Y8_in,
    input  logic signed [2*WIDTH-1:0] Y9_in,
    input  logic signed [2*WIDTH-1:0] Y10_in,
    input  logic signed [2*WIDTH-1:0] Y11_in,
    input  logic signed [2*WIDTH-1:0] Y12_in,
    input  logic signed [2*WIDTH-1:0] Y13_in,
    input  logic signed [2*WIDTH-1:0] Y14_in,
    input  logic signed [2*WIDTH-1:0] Y15_in,
    input  logic signed [2*WIDTH-1:0] Y16_in,
    output logic signed [WIDTH-1:0]   m_data,
    output logic [3:0]                m_index,
    output logic                      m_valid,
    output logic                      m_last,
    input  logic                      m_ready,
    output logic                      busy,
    output logic                      done
);

    typedef logic signed [2*WIDTH-1:0] yw_t;
    typedef logic signed [WIDTH-1:0]   px_t;

    localparam int SW_EFF = (SWEEPS < 1) ? 1 : SWEEPS;
    localparam int CW = $clog2(SW_EFF + 1);
    localparam logic [CW-1:0] SW_MAX = CW'(SW_EFF);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

`ifdef CNN_UNLOAD_BINARY_EN
    function automatic px_t conv(input yw_t y);
        conv = y[2*WIDTH-1] ? '1 : px_t'(1);
    endfunction
`else
    localparam yw_t SAT_HI = yw_t'((1 << (WIDTH - 1)) - 1);
    localparam yw_t SAT_LO = ~SAT_HI;

    // Clamp on the full-width shifted value so wrap-around never leaks out.
    function automatic px_t conv(input yw_t y);
        yw_t t;
        t = y >>> SHIFT;
        if (t > SAT_HI)      conv = SAT_HI[WIDTH-1:0];
        else if (t < SAT_LO) conv = SAT_LO[WIDTH-1:0];
        else                 conv = t[WIDTH-1:0];
    endfunction
`endif

    yw_t y_in [16];
    assign y_in[0]  = Y1_in;
    assign y_in[1]  = Y2_in;
    assign y_in[2]  = Y3_in;
    assign y_in[3]  = Y4_in;
    assign y_in[4]  = Y5_in;
    assign y_in[5]  = Y6_in;
    assign y_in[6]  = Y7_in;
    assign y_in[7]  = Y8_in;
    assign y_in[8]  = Y9_in;
    assign y_in[9]  = Y10_in;
    assign y_in[10] = Y11_in;
    assign y_in[11] = Y12_in;
    assign y_in[12] = Y13_in;
    assign y_in[13] = Y14_in;
    assign y_in[14] = Y15_in;
    assign y_in[15] = Y16_in;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    px_t           data_q, data_d;
    logic          done_q, done_d;
    logic          capture;
    yw_t           shadow_q [16];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        done_d  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end
            end
            SETTLE: begin
                if (sweep_tick) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == SW_MAX) begin
                        // First pixel converts straight from the live grid value.
                        capture = 1'b1;
                        state_d = STREAM;
                        idx_d   = 4'd0;
                        cnt_d   = '0;
                        data_d  = conv(y_in[0]);
                    end
                end
            end
            STREAM: begin
                if (m_ready) begin
                    if (idx_q == 4'd15) begin
                        state_d = IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        data_d = conv(shadow_q[idx_d]);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            done_q  <= done_d;
            if (capture) begin
                for (int i = 0; i < 16; i++) shadow_q[i] <= y_in[i];
            end
        end
    end

    assign m_data  = data_q;
    assign m_index = idx_q;
    assign m_valid = (state_q == STREAM);
    assign m_last  = (state_q == STREAM) && (idx_q == 4'd15);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_cnn_grid_unloader.sv
// Directed bench for cnn_grid_unloader: capture timing, conversion,
// backpressure, capture isolation, ignore rules and mid-stream reset.
module tb_cnn_grid_unloader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic sweep_tick = 1'b0;
    logic m_ready = 1'b1;
    logic signed [17:0] y [16];
    logic signed [8:0] m_data;
    logic [3:0] m_index;
    logic m_valid, m_last, busy, done;

    int checks = 0;
    int errors = 0;
    int total_waits = 0;

    logic signed [8:0] e_ramp [16];
    logic signed [8:0] e_sat [16];
    logic signed [8:0] e_neg [16];

    always #5 clk = ~clk;

    cnn_grid_unloader #(.WIDTH(9), .SHIFT(8), .SWEEPS(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sweep_tick(sweep_tick),
        .Y1_in(y[0]), .Y2_in(y[1]), .Y3_in(y[2]), .Y4_in(y[3]),
        .Y5_in(y[4]), .Y6_in(y[5]), .Y7_in(y[6]), .Y8_in(y[7]),
        .Y9_in(y[8]), .Y10_in(y[9]), .Y11_in(y[10]), .Y12_in(y[11]),
        .Y13_in(y[12]), .Y14_in(y[13]), .Y15_in(y[14]), .Y16_in(y[15]),
        .m_data(m_data), .m_index(m_index), .m_valid(m_valid),
        .m_last(m_last), .m_ready(m_ready), .busy(busy), .done(done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sweep_tick = 1'b0;
            step();
            sweep_tick = 1'b1;
            step();
        end
        sweep_tick = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic stream_check(input string tag, input logic signed [8:0] exp [16],
                                input int stall_beat, input int stall_len,
                                input bit start_in_done);
        logic signed [8:0] hd;
        logic [3:0] hi;
        logic hl;
        int w;
        for (int i = 0; i < 16; i++) begin
            w = 0;
            while (m_valid !== 1'b1 && w < 40) begin
                step();
                w++;
            end
            total_waits += w;
            chk({tag, "_valid"}, m_valid, 1);
            chk($sformatf("%s_idx%0d", tag, i), m_index, i);
            chk($sformatf("%s_data%0d", tag, i), m_data, exp[i]);
            chk($sformatf("%s_last%0d", tag, i), m_last, (i == 15) ? 1 : 0);
            if (i == stall_beat) begin
                hd = m_data;
                hi = m_index;
                hl = m_last;
                m_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    chk({tag, "_stall_valid"}, m_valid, 1);
                    chk({tag, "_stall_data"}, m_data, hd);
                    chk({tag, "_stall_idx"}, m_index, hi);
                    chk({tag, "_stall_last"}, m_last, hl);
                end
                m_ready = 1'b1;
            end
            step();
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_valid_end"}, m_valid, 0);
        if (start_in_done) start = 1'b1;
        step();
        start = 1'b0;
        chk({tag, "_done_pulse"}, done, 0);
        if (start_in_done) chk({tag, "_restart"}, busy, 1);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) y[k] = 18'(256 * (k + 1));
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
`ifdef CNN_UNLOAD_BINARY_EN
            e_ramp[k] = 9'sd1;
            e_neg[k]  = -9'sd1;
`else
            e_ramp[k] = 9'(k + 1);
            e_neg[k]  = 9'(-(k + 1));
`endif
            y[k] = '0;
        end
`ifdef CNN_UNLOAD_BINARY_EN
        e_sat = '{1, -1, -1, 1, 1, -1, 1, 1, -1, -1, 1, 1, -1, -1, 1, -1};
`else
        e_sat = '{255, -256, -1, 0, 255, -256, 0, 1, -1, -2, 255, 255,
                  -256, -256, 1, -2};
`endif

        step();
        step();
        chk("rst_data", m_data, 0);
        chk("rst_index", m_index, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        step();

        // Ramp run, back-to-back start in the done cycle
        set_ramp();
        do_start();
        ticks(7);
        chk("t1_settle_valid", m_valid, 0);
        chk("t1_settle_busy", busy, 1);
        ticks(1);
        chk("t1_cap_valid", m_valid, 1);
        stream_check("t1", e_ramp, -1, 0, 1'b1);

        // Saturation run (already in SETTLE)
        y = '{65535, -70000, -1, 0, 131071, -131072, 255, 256, -256, -257,
              65280, 65536, -65536, -65537, 511, -512};
        ticks(8);
        stream_check("t2", e_sat, -1, 0, 1'b0);

        // Backpressure on beat 3
        set_ramp();
        do_start();
        ticks(8);
        stream_check("t3", e_ramp, 3, 5, 1'b0);

        // Capture isolation: grid values scrambled every cycle after capture
        for (int k = 0; k < 16; k++) y[k] = 18'(-256 * (k + 1));
        do_start();
        ticks(8);
        fork
            begin
                for (int n = 0; n < 20; n++) begin
                    for (int k = 0; k < 16; k++) y[k] = 18'($urandom);
                    step();
                end
            end
            stream_check("t4", e_neg, -1, 0, 1'b0);
        join

        // Ignore rules
        set_ramp();
        ticks(3);
        chk("t5_idle_ticks", busy, 0);
        do_start();
        ticks(4);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_settle_start", m_valid, 0);
        ticks(3);
        chk("t5_seven_ticks", m_valid, 0);
        ticks(1);
        chk("t5_eighth_tick", m_valid, 1);
        fork
            begin
                start = 1'b1;
                sweep_tick = 1'b1;
                for (int n = 0; n < 5; n++) step();
                start = 1'b0;
                sweep_tick = 1'b0;
            end
            stream_check("t5", e_ramp, -1, 0, 1'b0);
        join

        // Reset while beat 7 is on the bus
        do_start();
        ticks(8);
        for (int n = 0; n < 7; n++) step();
        chk("t6_idx7", m_index, 7);
        rst_n = 1'b0;
        step();
        chk("t6_rst_data", m_data, 0);
        chk("t6_rst_index", m_index, 0);
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_last", m_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        rst_n = 1'b1;
        step();
        chk("t6_no_done", done, 0);
        do_start();
        ticks(8);
        stream_check("t6", e_ramp, -1, 0, 1'b0);

        chk("no_bubbles", total_waits, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
